// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot sensor sequence generator.
package parking_pkg;

  localparam int unsigned DWELL_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_GAP
  } state_e;

  typedef enum logic {
    DIR_ENTER,
    DIR_EXIT
  } dir_e;

  // Sensor pattern {a,b} for a phase; an exit is the enter pattern with the phases mirrored.
  function automatic logic [1:0] sensor_ab(input state_e st, input dir_e dir);
    logic [1:0] ab;
    ab = 2'b00;
    case (st)
      ST_P1:   ab = (dir == DIR_ENTER) ? 2'b10 : 2'b01;
      ST_P2:   ab = 2'b11;
      ST_P3:   ab = (dir == DIR_ENTER) ? 2'b01 : 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable 8-bit down-counter that parks at zero; reports zero now and after this edge.
module dwell_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero,
  output logic       zero_next
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

  assign zero      = (cnt_q == 8'd0);
  assign zero_next = (cnt_d == 8'd0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Emulates the outer/inner sensors of a parking gate: one enter or exit pattern per request.
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enter_req,
  input  logic exit_req,
  output logic a,
  output logic b,
  output logic busy,
  output logic done
);

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load, zero, zero_next;

  dwell_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (RELOAD),
    .zero      (zero),
    .zero_next (zero_next)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enter_req) begin
          state_d = ST_P1;
          dir_d   = DIR_ENTER;
          load    = 1'b1;
        end else if (exit_req) begin
          state_d = ST_P1;
          dir_d   = DIR_EXIT;
          load    = 1'b1;
        end
      end
      ST_P1: if (zero) begin state_d = ST_P2;  load = 1'b1; end
      ST_P2: if (zero) begin state_d = ST_P3;  load = 1'b1; end
      ST_P3: if (zero) begin state_d = ST_GAP; load = 1'b1; end
      ST_GAP: if (zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    ab_d   = sensor_ab(state_d, dir_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP) && zero_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_ENTER;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a    = ab_q[1];
  assign b    = ab_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Bench for parking_sensor_gen at DWELL=2 and DWELL=1 with a sequence-offset model and a sensor decoder.
module tb_parking_sensor_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2 = 1'b1, en2 = 1'b0, ex2 = 1'b0, a2, b2, busy2, done2;
  logic rst1 = 1'b1, en1 = 1'b0, ex1 = 1'b0, a1, b1, busy1, done1;

  parking_sensor_gen #(.DWELL(2)) dut2 (
    .clk(clk), .reset(rst2), .enter_req(en2), .exit_req(ex2),
    .a(a2), .b(b2), .busy(busy2), .done(done2)
  );

  parking_sensor_gen #(.DWELL(1)) dut1 (
    .clk(clk), .reset(rst1), .enter_req(en1), .exit_req(ex1),
    .a(a1), .b(b1), .busy(busy1), .done(done1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the cycle offset since the accepting edge, -1 when idle.
  int m_t[2] = '{-1, -1};
  bit m_ex[2] = '{1'b0, 1'b0};
  bit started = 1'b0;

  function automatic logic [3:0] model_out(input int t, input bit ex, input int dw);
    int ph;
    logic [1:0] ab;
    if (t < 0) return 4'b0000;
    ph = t / dw;
    case (ph)
      0:       ab = ex ? 2'b01 : 2'b10;
      1:       ab = 2'b11;
      2:       ab = ex ? 2'b10 : 2'b01;
      default: ab = 2'b00;
    endcase
    return {ab, 1'b1, (t == 4 * dw - 1)};
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst2) m_t[0] <= -1;
    else if (m_t[0] < 0) begin
      if (en2 || ex2) begin m_t[0] <= 0; m_ex[0] <= !en2; end
    end else m_t[0] <= (m_t[0] + 1 == 8) ? -1 : m_t[0] + 1;

    if (rst1) m_t[1] <= -1;
    else if (m_t[1] < 0) begin
      if (en1 || ex1) begin m_t[1] <= 0; m_ex[1] <= !en1; end
    end else m_t[1] <= (m_t[1] + 1 == 4) ? -1 : m_t[1] + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_dw2", 8'({a2, b2, busy2, done2}), 8'(model_out(m_t[0], m_ex[0], 2)));
      check("model_dw1", 8'({a1, b1, busy1, done1}), 8'(model_out(m_t[1], m_ex[1], 1)));
    end
  end

  // Sensor decoder fed from dut2: collects distinct non-idle patterns until the gate clears.
  int dec_enter = 0;
  int dec_exit  = 0;
  int hist      = 0;
  logic [1:0] prev_ab = 2'b00;

  always @(negedge clk) begin
    if ({a2, b2} != prev_ab) begin
      if ({a2, b2} == 2'b00) begin
        if ((hist & 63) == 6'b101101) dec_enter++;
        else if ((hist & 63) == 6'b011110) dec_exit++;
        hist = 0;
      end else begin
        hist = (hist << 2) | int'({a2, b2});
      end
      prev_ab = {a2, b2};
    end
  end

  initial begin
    logic [1:0] ent_ab[8];
    logic [1:0] ext_ab[8];
    int n_done, n_busy;
    ent_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    ext_ab = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};

    repeat (2) @(negedge clk);
    check("reset_dw2", 8'({a2, b2, busy2, done2}), 8'h00);
    check("reset_dw1", 8'({a1, b1, busy1, done1}), 8'h00);
    rst2 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("enter_ab", 8'({a2, b2}), 8'(ent_ab[i]));
      check("enter_busy", 8'(busy2), 8'd1);
      check("enter_done", 8'(done2), 8'(i == 7));
      @(negedge clk);
    end
    check("enter_idle_busy", 8'(busy2), 8'd0);

    ex2 = 1'b1;
    @(negedge clk);
    ex2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("exit_ab", 8'({a2, b2}), 8'(ext_ab[i]));
      check("exit_done", 8'(done2), 8'(i == 7));
      @(negedge clk);
    end
    check("exit_idle_busy", 8'(busy2), 8'd0);

    en2 = 1'b1;
    ex2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    ex2 = 1'b0;
    check("both_first_ab", 8'({a2, b2}), 8'h2);
    @(negedge clk);
    ex2 = 1'b1;
    @(negedge clk);
    ex2 = 1'b0;
    check("both_dir_kept", 8'({a2, b2}), 8'h3);
    repeat (5) @(negedge clk);
    check("both_done", 8'(done2), 8'd1);
    @(negedge clk);
    check("busy_req_dropped0", 8'(busy2), 8'd0);
    @(negedge clk);
    check("busy_req_dropped1", 8'(busy2), 8'd0);

    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_p2", 8'({a2, b2}), 8'h3);
    rst2 = 1'b1;
    en2  = 1'b1;
    @(negedge clk);
    check("abort_outputs", 8'({a2, b2, busy2, done2}), 8'h00);
    rst2 = 1'b0;
    en2  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", 8'({busy2, done2}), 8'h0);
    end
    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      n_done += int'(done2);
      n_busy += int'(busy2);
      @(negedge clk);
    end
    check("after_abort_dones", 8'(n_done), 8'd1);
    check("after_abort_busy", 8'(n_busy), 8'd8);

    en1 = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      check("dw1_done", 8'(done1), 8'((j % 5) == 3));
      check("dw1_busy", 8'(busy1), 8'((j % 5) != 4));
      @(negedge clk);
    end
    en1 = 1'b0;
    repeat (6) @(negedge clk);
    check("dw1_settled", 8'(busy1), 8'd0);

    dec_enter = 0;
    dec_exit  = 0;
    hist      = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) en2 = 1'b1;
      else       ex2 = 1'b1;
      @(negedge clk);
      en2 = 1'b0;
      ex2 = 1'b0;
      repeat (9) @(negedge clk);
    end
    check("decoder_enters", 8'(dec_enter), 8'd3);
    check("decoder_exits", 8'(dec_exit), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parking_sensor_gen.md
PARKING_SENSOR_GEN -- requirements
Module: parking_sensor_gen

Interface
REQ-001 SHALL have parameter DWELL, default 4, giving cycles each sensor phase is held; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enter_req, input, 1: request to emit one car-entering sensor sequence.
REQ-005 SHALL have port exit_req, input, 1: request to emit one car-exiting sensor sequence.
REQ-006 SHALL have port a, output, 1: emulated outer sensor, 1 = blocked.
REQ-007 SHALL have port b, output, 1: emulated inner sensor, 1 = blocked.
REQ-008 SHALL have port busy, output, 1: high while a sequence is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking sequence completion.

Function
REQ-010 SHALL implement FSM states IDLE, P1, P2, P3, GAP, plus a direction register (ENTER/EXIT) and an 8-bit dwell counter.
REQ-011 SHALL sample requests only at a posedge where state is IDLE; requests arriving at any other time are ignored, not queued.
REQ-012 SHALL give enter_req priority over exit_req when both are high at an accepting edge.
REQ-013 SHALL, on acceptance at edge k, enter P1 at k, with the counter loaded to DWELL-1.
REQ-014 SHALL hold each of P1, P2, P3, GAP for exactly DWELL cycles, counting down to 0, then advance and reload.
REQ-015 SHALL drive {a,b} for ENTER as P1=10, P2=11, P3=01, GAP=00.
REQ-016 SHALL drive {a,b} for EXIT as P1=01, P2=11, P3=10, GAP=00.
REQ-017 SHALL drive {a,b}=00 in IDLE.
REQ-018 SHALL drive a, b, busy, and done directly from registered state, with no combinational path from inputs to outputs.
REQ-019 SHALL hold busy high in every P1..GAP cycle (4*DWELL cycles) and low in IDLE.
REQ-020 SHALL assert done only in the final GAP cycle (counter 0); the FSM returns to IDLE at that cycle's closing edge.
REQ-021 SHALL make the earliest next acceptance edge 4*DWELL+1 cycles after the previous acceptance edge.
REQ-022 SHALL behave correctly with DWELL=1: each phase lasts one cycle, no counter underflow.
REQ-023 SHALL keep the direction register constant for the entire sequence regardless of input changes.

Reset
REQ-024 SHALL, when reset is high at a posedge, force state IDLE, counter 0, direction ENTER, and a=0, b=0, busy=0, done=0 by the following cycle.
REQ-025 SHALL abort any in-progress sequence on reset with no done pulse; outputs return to 00.
REQ-026 SHALL ignore enter_req and exit_req at any edge where reset is high.

Structure
REQ-027 SHALL place the state enum, the direction enum, and the DWELL default constant in shared package parking_pkg.
REQ-028 SHALL contain one natural sub-module, dwell_timer (load, count-down, zero flag); inlining it is permitted.

Verification
REQ-029 SHALL cover: DWELL=2, enter_req pulse -> {a,b} = 10,10,11,11,01,01,00,00; busy high 8 cycles; done high in the 8th cycle only.
REQ-030 SHALL cover: DWELL=2, exit_req pulse -> {a,b} = 01,01,11,11,10,10,00,00; done in the 8th cycle.
REQ-031 SHALL cover: enter_req and exit_req high together -> ENTER sequence emitted; a second request during busy -> no second sequence.
REQ-032 SHALL cover: reset asserted in P2 -> next cycle {a,b}=00, busy=0, and no done pulse; a subsequent enter_req produces a full sequence.
REQ-033 SHALL cover: DWELL=1, enter_req held high continuously -> back-to-back sequences of 4 cycles plus 1 IDLE cycle each, with done every 5th cycle.
REQ-034 SHALL cover: loopback into the team's parking-lot sensor decoder, 3 enters then 1 exit -> decoder produces exactly 3 enter pulses and 1 exit pulse.
